// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response and memory-pin bundle for mem_arbiter
//
// Purpose: groups the two requester ports, the shared read-return bus and the
//          single-port memory pins into one interface.
// Modports:
//   slave  - arbiter view: samples requests and memory read data, drives
//            grants, read return and memory address/data/strobes.
//   master - requester/memory view: the mirror image of slave.
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : held request per port
//   gnt0/gnt1       : access performed this cycle for that port
//   rvalid0/rvalid1 : one-cycle pulse, rdata valid for that port
//   rdata           : registered read data shared by both ports
//   mem_address, mem_data_in, mem_rd, mem_wr : to memory
//   mem_data_out    : from memory (combinational read)
interface mem_arbiter_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [AWIDTH-1:0] addr0;
  logic [AWIDTH-1:0] addr1;
  logic [DWIDTH-1:0] wdata0;
  logic [DWIDTH-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DWIDTH-1:0] rdata;
  logic [AWIDTH-1:0] mem_address;
  logic [DWIDTH-1:0] mem_data_in;
  logic [DWIDTH-1:0] mem_data_out;
  logic              mem_rd;
  logic              mem_wr;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_address, mem_data_in, mem_rd, mem_wr
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_address, mem_data_in, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a single-port memory
//
// Purpose: grants one memory access per cycle to one of two held requests,
//          drives the memory pins for the granted port and returns registered
//          read data one cycle after a read access.
// Ports:
//   clk   - single clock, all state updates on rising edge
//   reset - synchronous, active-high
//   bus   - mem_arbiter_if.slave (requests, grants, read return, memory pins)
// Configuration:
//   MEM_ARB_FIXED_PRIO_EN - defined: port 0 wins every tie in IDLE and the
//                           last-served register is removed.
//                           undefined (default): round robin on ties.
module mem_arbiter #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              acc0;
  logic              acc1;
  logic              rd0;
  logic              rd1;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DWIDTH-1:0] rdata_q;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic last;  // port most recently served; reset to 1 so port 0 wins the first tie
`endif

  // Reset masks the access combinationally so an access cycle interrupted by
  // reset neither writes, reads, nor schedules a read return.
  assign acc0 = (state == ACC0) && !reset;
  assign acc1 = (state == ACC1) && !reset;
  assign rd0  = acc0 && !bus.we0;
  assign rd1  = acc1 && !bus.we1;

  // The granted port's own req is ignored while leaving its ACC state: it may
  // still show the request just served, so only the other port is considered.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          state_nxt = ACC0;
`else
          state_nxt = last ? ACC0 : ACC1;
`endif
        end else if (bus.req0) begin
          state_nxt = ACC0;
        end else if (bus.req1) begin
          state_nxt = ACC1;
        end
      end
      ACC0:    state_nxt = bus.req1 ? ACC1 : IDLE;
      ACC1:    state_nxt = bus.req0 ? ACC0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rd0 || rd1) begin
        rdata_q <= bus.mem_data_out;
      end
`ifndef MEM_ARB_FIXED_PRIO_EN
      if (acc0) begin
        last <= 1'b0;
      end else if (acc1) begin
        last <= 1'b1;
      end
`endif
    end
  end

  assign bus.gnt0        = acc0;
  assign bus.gnt1        = acc1;
  assign bus.rvalid0     = rvalid0_q;
  assign bus.rvalid1     = rvalid1_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_rd      = rd0 || rd1;
  assign bus.mem_wr      = (acc0 && bus.we0) || (acc1 && bus.we1);
  assign bus.mem_address = acc0 ? bus.addr0  : (acc1 ? bus.addr1  : {AWIDTH{1'b0}});
  assign bus.mem_data_in = acc0 ? bus.wdata0 : (acc1 ? bus.wdata1 : {DWIDTH{1'b0}});

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_clr = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.AWIDTH(8), .DWIDTH(8)) bus ();

  mem_arbiter #(.AWIDTH(8), .DWIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory model: combinational read, write on the edge closing a wr cycle.
  logic [7:0] mem [256];
  assign bus.mem_data_out = mem[bus.mem_address];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.mem_wr) begin
      mem[bus.mem_address] <= bus.mem_data_in;
    end
  end

  typedef struct {
    int         port;
    logic [7:0] data;
    int         cycle;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      gnt_count = 0;
  int      last_gnt_cyc = 0;
  logic    prev_g0 = 1'b0;
  logic    prev_g1 = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every rvalid, checks grant rules.
  always @(negedge clk) begin
    if (reset) begin
      prev_g0 <= 1'b0;
      prev_g1 <= 1'b0;
    end else begin
      if (bus.gnt0 || bus.gnt1) begin
        gnt_count++;
        last_gnt_cyc = cyc;
        check("gnt_exclusive", int'(bus.gnt0 && bus.gnt1), 0);
        check("gnt_not_consecutive", int'((bus.gnt0 && prev_g0) || (bus.gnt1 && prev_g1)), 0);
      end
      prev_g0 <= bus.gnt0;
      prev_g1 <= bus.gnt1;
      if (bus.rvalid0 || bus.rvalid1) begin
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 1, 0);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rvalid_both", int'(bus.rvalid0 && bus.rvalid1), 0);
          check("rvalid_port", bus.rvalid1 ? 1 : 0, e.port);
          check("rdata", int'(bus.rdata), int'(e.data));
          check("rvalid_cycle", cyc, e.cycle);
        end
      end
    end
  end

  task automatic drive(input int p, input logic rq, input logic we,
                       input logic [7:0] a, input logic [7:0] wd);
    if (p == 0) begin
      bus.req0 = rq; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
    end else begin
      bus.req1 = rq; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends
  // the grant cycle, with req dropped (caller may present the next request).
  task automatic access(input int p, input logic we, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd,
                        output int gcyc);
    bit got;
    rd_exp_t e;
    got  = 1'b0;
    gcyc = -1;
    drive(p, 1'b1, we, a, wd);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.gnt0 : bus.gnt1) begin
        got  = 1'b1;
        gcyc = cyc;
        if (!we) begin
          e.port  = p;
          e.data  = exp_rd;
          e.cycle = cyc + 1;
          rd_q.push_back(e);
        end
      end
    end
    check("grant_within_budget", int'(got), 1);
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int g0, g1, c0, gc0;

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    reset   = 1'b0;

    // Reset, idle: all outputs quiet for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_mem_wr", int'(bus.mem_wr), 0);
      check("idle_outputs", int'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                                  bus.mem_rd, bus.rdata, bus.mem_address,
                                  bus.mem_data_in}), 0);
    end
    @(posedge clk); #1;

    // Single write then read on port 0.
    access(0, 1'b1, 8'h05, 8'hA3, 8'h00, g0);
    access(0, 1'b0, 8'h05, 8'h00, 8'hA3, g0);
    repeat (2) @(posedge clk); #1;

    // Preload for contention through port 1.
    access(1, 1'b1, 8'h10, 8'h11, 8'h00, g1);
    access(1, 1'b1, 8'h20, 8'h22, 8'h00, g1);
    repeat (2) @(posedge clk); #1;

    // Contention from reset: port 0 wins the first tie, then port 1.
    do_reset();
    c0 = cyc;
    fork
      access(0, 1'b0, 8'h10, 8'h00, 8'h11, g0);
      access(1, 1'b0, 8'h20, 8'h00, 8'h22, g1);
    join
    check("tie1_gnt0_cycle", g0, c0 + 1);
    check("tie1_gnt1_cycle", g1, c0 + 2);
    repeat (3) @(posedge clk); #1;
    c0 = cyc;
    fork
      access(0, 1'b0, 8'h20, 8'h00, 8'h22, g0);
      access(1, 1'b0, 8'h10, 8'h00, 8'h11, g1);
    join
    check("tie2_gnt0_cycle", g0, c0 + 1);
    check("tie2_gnt1_cycle", g1, c0 + 2);
    repeat (3) @(posedge clk); #1;

    // Continuous requests: 16 alternating grants in 16 cycles.
    c0  = cyc;
    gc0 = gnt_count;
    fork
      begin
        int d;
        for (int i = 0; i < 8; i++)
          access(0, 1'b0, i[0] ? 8'h10 : 8'h05, 8'h00, i[0] ? 8'h11 : 8'hA3, d);
      end
      begin
        int d;
        for (int i = 0; i < 8; i++)
          access(1, 1'b0, i[0] ? 8'h10 : 8'h20, 8'h00, i[0] ? 8'h11 : 8'h22, d);
      end
    join
    check("burst_grant_count", gnt_count - gc0, 16);
    check("burst_last_grant_cycle", last_gnt_cyc, c0 + 16);
    repeat (3) @(posedge clk); #1;

    // Reset asserted during an ACC0 write to 0x07.
    drive(0, 1'b1, 1'b1, 8'h07, 8'hFF);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_mid_mem_wr", int'(bus.mem_wr), 0);
    check("rst_mid_gnt0", int'(bus.gnt0), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("rst_after_quiet", int'({bus.gnt0, bus.gnt1, bus.mem_wr, bus.rvalid0}), 0);
    check("rst_mem07", int'(mem[8'h07]), 0);
    @(posedge clk); #1;
    c0 = cyc;
    access(1, 1'b0, 8'h07, 8'h00, 8'h00, g1);
    check("rst_idle_latency", g1, c0 + 1);
    repeat (2) @(posedge clk); #1;

    // Port 0 writes 0x30, port 1 reads it in the very next cycle.
    fork
      access(0, 1'b1, 8'h30, 8'h5C, 8'h00, g0);
      begin
        @(posedge clk); #1;
        access(1, 1'b0, 8'h30, 8'h00, 8'h5C, g1);
      end
    join
    check("overlap_order", g1, g0 + 1);
    repeat (4) @(posedge clk);

    check("scoreboard_drained", rd_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
